// File: rtl/bus_initiator_if.sv
// Command and bus-control bundle between a command source and bus_initiator.
// The tri-state data bus stays a plain inout port on the initiator so it resolves like any shared wire.
interface bus_initiator_if #(
  parameter int NSEL = 4,
  parameter int AW   = 2
);
  logic            CmdValid;
  logic            CmdReady;
  logic [1:0]      CmdOp;
  logic [AW-1:0]   CmdSrc;
  logic [AW-1:0]   CmdDst;
  logic [7:0]      CmdData;
  logic            RdValid;
  logic [7:0]      RdData;
  logic            Busy;
  logic [7:0]      TxCount;
  logic [NSEL-1:0] Sel;
  logic            RnW;

  modport master (
    input  CmdValid, CmdOp, CmdSrc, CmdDst, CmdData,
    output CmdReady, RdValid, RdData, Busy, TxCount, Sel, RnW
  );

  modport slave (
    output CmdValid, CmdOp, CmdSrc, CmdDst, CmdData,
    input  CmdReady, RdValid, RdData, Busy, TxCount, Sel, RnW
  );
endinterface

// File: rtl/bus_initiator.sv
// Single-outstanding bus initiator: runs WRITE, READ and MOVE cycles on a one-hot-selected
// shared tri-state bus, always returning to IDLE for a bus-idle cycle between transactions.
module bus_initiator #(
  parameter int NSEL = 4,
  parameter int AW   = 2
) (
  input  logic            Clk,
  input  logic            Rst,
  bus_initiator_if.master bus,
  inout  wire [7:0]       Dio
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD      = 3'd2,
    MV_RD   = 3'd3,
    MV_TURN = 3'd4,
    MV_WR   = 3'd5
  } state_e;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_MOVE  = 2'b10;

  state_e          state;
  state_e          nextState;
  logic [AW-1:0]   srcReg;
  logic [AW-1:0]   dstReg;
  logic [7:0]      dataReg;
  logic [7:0]      holdReg;
  logic [7:0]      rdData;
  logic [7:0]      txCount;
  logic            rdValid;
  logic            cmdReady;
  logic            accept;
  logic [NSEL-1:0] sel;
  logic            rnw;
  logic            dioOe;
  logic [7:0]      dioOut;

  assign accept = bus.CmdValid && cmdReady;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (accept) begin
          case (bus.CmdOp)
            OP_WRITE: nextState = WR;
            OP_READ:  nextState = RD;
            OP_MOVE:  nextState = MV_RD;
            default:  nextState = IDLE;
          endcase
        end
      end
      WR:      nextState = IDLE;
      RD:      nextState = IDLE;
      MV_RD:   nextState = MV_TURN;
      MV_TURN: nextState = MV_WR;
      MV_WR:   nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Bus controls are decoded from the registered state alone, so they never glitch on command inputs.
  always_comb begin
    sel      = '0;
    rnw      = 1'b1;
    dioOe    = 1'b0;
    dioOut   = dataReg;
    cmdReady = 1'b0;
    case (state)
      IDLE: cmdReady = 1'b1;
      WR: begin
        sel[dstReg] = 1'b1;
        rnw         = 1'b0;
        dioOe       = 1'b1;
      end
      RD:      sel[srcReg] = 1'b1;
      MV_RD:   sel[srcReg] = 1'b1;
      MV_TURN: sel = '0;
      MV_WR: begin
        sel[dstReg] = 1'b1;
        rnw         = 1'b0;
        dioOe       = 1'b1;
        dioOut      = holdReg;
      end
      default: cmdReady = 1'b0;
    endcase
  end

  // Captures happen at the closing edge of the read cycle; a MOVE keeps its data out of RdData.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      srcReg  <= '0;
      dstReg  <= '0;
      dataReg <= 8'h00;
      holdReg <= 8'h00;
      rdData  <= 8'h00;
      rdValid <= 1'b0;
      txCount <= 8'h00;
    end else begin
      rdValid <= (state == RD);
      if (state == RD) begin
        rdData <= Dio;
      end
      if (state == MV_RD) begin
        holdReg <= Dio;
      end
      if ((state == WR) || (state == RD) || (state == MV_RD) || (state == MV_WR)) begin
        txCount <= txCount + 8'd1;
      end
      if (accept) begin
        srcReg  <= bus.CmdSrc;
        dstReg  <= bus.CmdDst;
        dataReg <= bus.CmdData;
      end
    end
  end

  assign Dio          = dioOe ? dioOut : 8'bz;
  assign bus.CmdReady = cmdReady;
  assign bus.Busy     = (state != IDLE);
  assign bus.Sel      = sel;
  assign bus.RnW      = rnw;
  assign bus.RdValid  = rdValid;
  assign bus.RdData   = rdData;
  assign bus.TxCount  = txCount;

endmodule
